// File: rtl/risc_core_multicycle_if.sv
// Program-memory bus between the multicycle core and its external
// combinational instruction store, plus the fetch stall request.
interface risc_core_multicycle_if #(
   parameter int PC_W    = 4,
   parameter int INSTR_W = 9
);
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               stall;

   modport master (
      output imem_addr,
      input  imem_data,
      input  stall
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output stall
   );
endinterface

// File: rtl/risc_core_multicycle.sv
// Two-state (fetch/execute) sequenced RISC core with a parametrised
// register file, carry/zero flags, load-immediate, BEQZ and HALT.
module risc_core_multicycle #(
   parameter int DATA_W  = 4,
   parameter int REG_AW  = 2,
   parameter int PC_W    = 4,
   parameter int INSTR_W = 3 + 3*REG_AW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   risc_core_multicycle_if.master imem,
   output logic [PC_W-1:0]       pc,
   output logic                  halted,
   output logic                  wb_en,
   output logic [REG_AW-1:0]     wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  flag_z,
   output logic                  flag_c
);

   localparam int NREG = 1 << REG_AW;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_BEQZ = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   logic [1:0]         state;
   logic [INSTR_W-1:0] ir;
   logic [DATA_W-1:0]  regs [NREG];

   logic [2:0]         opcode;
   logic [REG_AW-1:0]  rs1;
   logic [REG_AW-1:0]  rs2;
   logic [REG_AW-1:0]  rd;
   logic [DATA_W-1:0]  op_a;
   logic [DATA_W-1:0]  op_b;

   logic [DATA_W:0]    sum_ext;
   logic [DATA_W-1:0]  result;
   logic               res_c;
   logic               res_z;
   logic               do_write;
   logic               upd_flags;
   logic               branch_taken;
   logic               write_fire;
   logic [PC_W-1:0]    pc_next;

   logic [REG_AW-1:0]  wb_addr_hold;
   logic [DATA_W-1:0]  wb_data_hold;

   assign opcode = ir[INSTR_W-1 -: 3];
   assign rs1    = ir[3*REG_AW-1 -: REG_AW];
   assign rs2    = ir[2*REG_AW-1 -: REG_AW];
   assign rd     = ir[REG_AW-1:0];

   // Reads are combinational so rd==rs1/rs2 sees the pre-write values.
   assign op_a = regs[rs1];
   assign op_b = regs[rs2];

   assign imem.imem_addr = pc;

   // Decode the latched instruction into a result, flag values and control.
   always_comb begin
      sum_ext      = '0;
      result       = '0;
      res_c        = flag_c;
      res_z        = flag_z;
      do_write     = 1'b0;
      upd_flags    = 1'b0;
      branch_taken = 1'b0;
      case (opcode)
         OP_ADD: begin
            sum_ext   = {1'b0, op_a} + {1'b0, op_b};
            result    = sum_ext[DATA_W-1:0];
            res_c     = sum_ext[DATA_W];
            do_write  = 1'b1;
            upd_flags = 1'b1;
         end
         OP_SUB: begin
            result    = op_a - op_b;
            res_c     = (op_a < op_b);
            do_write  = 1'b1;
            upd_flags = 1'b1;
         end
         OP_AND: begin
            result    = op_a & op_b;
            res_c     = 1'b0;
            do_write  = 1'b1;
            upd_flags = 1'b1;
         end
         OP_OR: begin
            result    = op_a | op_b;
            res_c     = 1'b0;
            do_write  = 1'b1;
            upd_flags = 1'b1;
         end
         OP_XOR: begin
            result    = op_a ^ op_b;
            res_c     = 1'b0;
            do_write  = 1'b1;
            upd_flags = 1'b1;
         end
         OP_LDI: begin
            result   = DATA_W'({rs1, rs2});
            do_write = 1'b1;
         end
         OP_BEQZ: begin
            branch_taken = (op_a == '0);
         end
         default: begin
         end
      endcase
      if (upd_flags) begin
         res_z = (result == '0);
      end
   end

   assign write_fire = (state == ST_EXEC) && do_write;
   assign pc_next    = branch_taken ? PC_W'({rs2, rd}) : pc + PC_W'(1);

   // Write-back port is live during a writing EXEC and otherwise shows the last write.
   always_comb begin
      wb_en   = write_fire;
      wb_addr = write_fire ? rd     : wb_addr_hold;
      wb_data = write_fire ? result : wb_data_hold;
   end

   // Fetch/execute sequencer with PC, IR, flags and register file state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_FETCH;
         ir           <= '0;
         pc           <= '0;
         halted       <= 1'b0;
         flag_z       <= 1'b0;
         flag_c       <= 1'b0;
         wb_addr_hold <= '0;
         wb_data_hold <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            ST_FETCH: begin
               if (!imem.stall) begin
                  ir    <= imem.imem_data;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (write_fire) begin
                  regs[rd]     <= result;
                  wb_addr_hold <= rd;
                  wb_data_hold <= result;
               end
               if (upd_flags) begin
                  flag_z <= res_z;
                  flag_c <= res_c;
               end
               if (opcode == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
               end else begin
                  pc    <= pc_next;
                  state <= ST_FETCH;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc_core_multicycle.sv
// Self-checking bench for risc_core_multicycle: directed scenarios plus
// random programs compared against an instruction-level reference model.
module tb_risc_core_multicycle;

   localparam int DATA_W  = 4;
   localparam int REG_AW  = 2;
   localparam int PC_W    = 4;
   localparam int INSTR_W = 3 + 3*REG_AW;
   localparam int NREG    = 1 << REG_AW;
   localparam int NPC     = 1 << PC_W;
   localparam int DMOD    = 1 << DATA_W;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic stall_r = 1'b0;

   logic [INSTR_W-1:0] prog [NPC];

   logic [PC_W-1:0]   pc;
   logic              halted;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              flag_z;
   logic              flag_c;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state (architectural, one step per instruction)
   int m_reg [NREG];
   int m_pc;
   bit m_z;
   bit m_c;
   bit m_halt;

   risc_core_multicycle_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   assign bus.imem_data = prog[bus.imem_addr];
   assign bus.stall     = stall_r;

   risc_core_multicycle #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW),
      .PC_W  (PC_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .imem   (bus),
      .pc     (pc),
      .halted (halted),
      .wb_en  (wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .flag_z (flag_z),
      .flag_c (flag_c)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [INSTR_W-1:0] enc(input int op, input int rs1, input int rs2, input int rd);
      return INSTR_W'((op << (3*REG_AW)) | (rs1 << (2*REG_AW)) | (rs2 << REG_AW) | rd);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NREG; i++) m_reg[i] = 0;
      m_pc   = 0;
      m_z    = 0;
      m_c    = 0;
      m_halt = 0;
   endfunction

   // Execute one instruction on the model; report the expected write-back.
   function automatic void model_step(input int ins, output bit x_wb, output int x_addr, output int x_data);
      int op, rs1, rs2, rd, a, b, res;
      op  = ins >> (3*REG_AW);
      rs1 = (ins >> (2*REG_AW)) % NREG;
      rs2 = (ins >> REG_AW) % NREG;
      rd  = ins % NREG;
      a   = m_reg[rs1];
      b   = m_reg[rs2];
      res = 0;
      x_wb = 0; x_addr = 0; x_data = 0;
      case (op)
         0: begin res = a + b; m_c = (res >= DMOD); res = res % DMOD; end
         1: begin m_c = (a < b); res = (a - b + DMOD) % DMOD; end
         2: begin res = a & b; m_c = 0; end
         3: begin res = a | b; m_c = 0; end
         4: begin res = a ^ b; m_c = 0; end
         5: res = (rs1 * NREG + rs2) % DMOD;
         default: ;
      endcase
      if (op <= 4) m_z = (res == 0);
      if (op <= 5) begin
         m_reg[rd] = res;
         x_wb = 1; x_addr = rd; x_data = res;
         m_pc = (m_pc + 1) % NPC;
      end else if (op == 6) begin
         m_pc = (a == 0) ? (rs2 * NREG + rd) % NPC : (m_pc + 1) % NPC;
      end else begin
         m_halt = 1;
      end
   endfunction

   task automatic fill_halt();
      for (int i = 0; i < NPC; i++) prog[i] = enc(7, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      stall_r = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Steps one instruction (FETCH edge then EXEC edge), sampling 1 time unit after each edge.
   task automatic exec_one(output logic [PC_W-1:0] f_pc, output logic e_wb, output logic [REG_AW-1:0] e_addr,
                           output logic [DATA_W-1:0] e_data, output logic [PC_W-1:0] n_pc,
                           output logic n_z, output logic n_c, output logic n_h, output logic n_wb);
      f_pc = pc;
      @(posedge clk); #1;
      e_wb   = wb_en;
      e_addr = wb_addr;
      e_data = wb_data;
      @(posedge clk); #1;
      n_pc = pc;
      n_z  = flag_z;
      n_c  = flag_c;
      n_h  = halted;
      n_wb = wb_en;
   endtask

   task automatic test_reset();
      fill_halt();
      rst_n = 1'b0;
      #12;
      n_cmp++; if (pc !== '0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
      n_cmp++; if (bus.imem_addr !== '0) begin n_bad++; $display("FAIL reset_imem_addr: got %0d want 0", bus.imem_addr); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_cmp++; if (wb_en !== 1'b0) begin n_bad++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
      n_cmp++; if ({flag_z, flag_c} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {flag_z, flag_c}); end
      n_cmp++; if ({wb_addr, wb_data} !== '0) begin n_bad++; $display("FAIL reset_wb_hold: got %h want 0", {wb_addr, wb_data}); end
   endtask

   task automatic test_program();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      int exp_addr [3] = '{1, 2, 3};
      int exp_data [3] = '{3, 2, 5};
      fill_halt();
      prog[0] = enc(5, 0, 3, 1);
      prog[1] = enc(5, 0, 2, 2);
      prog[2] = enc(0, 1, 2, 3);
      prog[3] = enc(7, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
         if (i < 3) begin
            n_cmp++; if (e_wb !== 1'b1) begin n_bad++; $display("FAIL prog_wb_en[%0d]: got %b want 1", i, e_wb); end
            n_cmp++; if (e_addr !== REG_AW'(exp_addr[i])) begin n_bad++; $display("FAIL prog_wb_addr[%0d]: got %0d want %0d", i, e_addr, exp_addr[i]); end
            n_cmp++; if (e_data !== DATA_W'(exp_data[i])) begin n_bad++; $display("FAIL prog_wb_data[%0d]: got %0d want %0d", i, e_data, exp_data[i]); end
            n_cmp++; if (n_h !== 1'b0) begin n_bad++; $display("FAIL prog_early_halt[%0d]: got %b want 0", i, n_h); end
         end else begin
            n_cmp++; if (e_wb !== 1'b0) begin n_bad++; $display("FAIL prog_halt_wb: got %b want 0", e_wb); end
            n_cmp++; if (n_h !== 1'b1) begin n_bad++; $display("FAIL prog_halted_cycle8: got %b want 1", n_h); end
            n_cmp++; if (n_pc !== PC_W'(3)) begin n_bad++; $display("FAIL prog_halt_pc: got %0d want 3", n_pc); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++; if ({pc, halted, wb_en} !== {PC_W'(3), 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL halt_hold[%0d]: got pc=%0d h=%b wb=%b want pc=3 h=1 wb=0", i, pc, halted, wb_en);
         end
      end
   endtask

   task automatic test_flags();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      bit x_wb; int x_addr, x_data;
      fill_halt();
      prog[0] = enc(5, 3, 3, 1);
      prog[1] = enc(5, 0, 1, 2);
      prog[2] = enc(0, 1, 2, 0);
      prog[3] = enc(1, 2, 1, 0);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         model_step(int'(prog[m_pc]), x_wb, x_addr, x_data);
         exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
         n_cmp++; if (e_wb !== x_wb) begin n_bad++; $display("FAIL flags_wb_en[%0d]: got %b want %b", i, e_wb, x_wb); end
         if (x_wb) begin
            n_cmp++; if ({e_addr, e_data} !== {REG_AW'(x_addr), DATA_W'(x_data)}) begin
               n_bad++; $display("FAIL flags_wb[%0d]: got r%0d=%0d want r%0d=%0d", i, e_addr, e_data, x_addr, x_data);
            end
         end
         n_cmp++; if ({n_z, n_c} !== {m_z, m_c}) begin n_bad++; $display("FAIL flags_zc[%0d]: got %b%b want %b%b", i, n_z, n_c, m_z, m_c); end
      end
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL flags_halted: got %b want 1", halted); end
   endtask

   task automatic test_branch();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      bit x_wb; int x_addr, x_data;
      int exp_pc [3] = '{10, 11, 12};
      fill_halt();
      prog[0]  = enc(6, 1, 2, 2);
      prog[10] = enc(5, 0, 1, 1);
      prog[11] = enc(6, 1, 2, 2);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         model_step(int'(prog[m_pc]), x_wb, x_addr, x_data);
         exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
         n_cmp++; if (e_wb !== x_wb) begin n_bad++; $display("FAIL branch_wb_en[%0d]: got %b want %b", i, e_wb, x_wb); end
         n_cmp++; if (n_pc !== PC_W'(exp_pc[i])) begin n_bad++; $display("FAIL branch_pc[%0d]: got %0d want %0d", i, n_pc, exp_pc[i]); end
         n_cmp++; if (n_pc !== PC_W'(m_pc)) begin n_bad++; $display("FAIL branch_model_pc[%0d]: got %0d want %0d", i, n_pc, m_pc); end
      end
   endtask

   task automatic test_wrap();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      bit x_wb; int x_addr, x_data, p_pc;
      fill_halt();
      prog[0]  = enc(6, 0, 3, 2);
      prog[14] = enc(5, 0, 1, 1);
      prog[15] = enc(5, 1, 2, 2);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         p_pc = m_pc;
         model_step(int'(prog[m_pc]), x_wb, x_addr, x_data);
         exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
         n_cmp++; if (f_pc !== PC_W'(p_pc)) begin n_bad++; $display("FAIL wrap_fetch_pc[%0d]: got %0d want %0d", i, f_pc, p_pc); end
         n_cmp++; if (n_pc !== PC_W'(m_pc)) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", i, n_pc, m_pc); end
         n_cmp++; if (n_h !== 1'b0) begin n_bad++; $display("FAIL wrap_halted[%0d]: got %b want 0", i, n_h); end
      end
   endtask

   task automatic test_stall();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      fill_halt();
      prog[0] = enc(5, 2, 1, 3);
      prog[1] = enc(5, 1, 3, 2);
      do_reset();
      stall_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if ({pc, wb_en, halted} !== {PC_W'(0), 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got pc=%0d wb=%b h=%b want pc=0 wb=0 h=0", i, pc, wb_en, halted);
         end
      end
      stall_r = 1'b0;
      exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
      n_cmp++; if ({e_wb, e_addr, e_data} !== {1'b1, REG_AW'(3), DATA_W'(9)}) begin
         n_bad++; $display("FAIL stall_release_wb: got %b r%0d=%0d want 1 r3=9", e_wb, e_addr, e_data);
      end
      n_cmp++; if (n_pc !== PC_W'(1)) begin n_bad++; $display("FAIL stall_release_pc: got %0d want 1", n_pc); end
      // stall raised during EXEC must not stop the instruction completing
      @(posedge clk); #1;
      stall_r = 1'b1;
      n_cmp++; if ({wb_en, wb_addr, wb_data} !== {1'b1, REG_AW'(2), DATA_W'(7)}) begin
         n_bad++; $display("FAIL stall_exec_wb: got %b r%0d=%0d want 1 r2=7", wb_en, wb_addr, wb_data);
      end
      @(posedge clk); #1;
      n_cmp++; if (pc !== PC_W'(2)) begin n_bad++; $display("FAIL stall_exec_pc: got %0d want 2", pc); end
      n_cmp++; if ({wb_en, wb_addr, wb_data} !== {1'b0, REG_AW'(2), DATA_W'(7)}) begin
         n_bad++; $display("FAIL wb_hold: got %b r%0d=%0d want 0 r2=7", wb_en, wb_addr, wb_data);
      end
      stall_r = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      fill_halt();
      prog[0] = enc(5, 3, 3, 1);
      prog[1] = enc(5, 0, 1, 2);
      prog[2] = enc(0, 1, 2, 0);
      prog[3] = enc(0, 1, 2, 3);
      do_reset();
      for (int i = 0; i < 3; i++) exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
      n_cmp++; if ({n_z, n_c} !== 2'b11) begin n_bad++; $display("FAIL add_wrap_flags: got %b%b want 11", n_z, n_c); end
      @(posedge clk); #1;
      n_cmp++; if (wb_en !== 1'b1) begin n_bad++; $display("FAIL midexec_pre_wb: got %b want 1", wb_en); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({wb_en, pc, flag_z, flag_c, halted} !== '0) begin
         n_bad++; $display("FAIL midexec_async_clear: got wb=%b pc=%0d z=%b c=%b h=%b want all 0", wb_en, pc, flag_z, flag_c, halted);
      end
      prog[0] = enc(3, 1, 2, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
      n_cmp++; if ({e_wb, e_addr, e_data} !== {1'b1, REG_AW'(0), DATA_W'(0)}) begin
         n_bad++; $display("FAIL midexec_regs_cleared: got %b r%0d=%0d want 1 r0=0", e_wb, e_addr, e_data);
      end
      n_cmp++; if ({n_z, n_c} !== 2'b10) begin n_bad++; $display("FAIL midexec_flags_after: got %b%b want 10", n_z, n_c); end
   endtask

   task automatic test_random();
      logic [PC_W-1:0] f_pc, n_pc;
      logic e_wb, n_z, n_c, n_h, n_wb;
      logic [REG_AW-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      bit x_wb; int x_addr, x_data, p_pc, op;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NPC; i++) begin
            op = $urandom_range(0, 9);
            if (op > 6) op = 5;
            if ($urandom_range(0, 24) == 0) op = 7;
            prog[i] = enc(op, $urandom_range(0, NREG-1), $urandom_range(0, NREG-1), $urandom_range(0, NREG-1));
         end
         do_reset();
         for (int i = 0; i < 30 && !m_halt; i++) begin
            p_pc = m_pc;
            model_step(int'(prog[m_pc]), x_wb, x_addr, x_data);
            exec_one(f_pc, e_wb, e_addr, e_data, n_pc, n_z, n_c, n_h, n_wb);
            n_cmp++; if (f_pc !== PC_W'(p_pc)) begin n_bad++; $display("FAIL rnd_fetch_pc[%0d.%0d]: got %0d want %0d", r, i, f_pc, p_pc); end
            n_cmp++; if (e_wb !== x_wb) begin n_bad++; $display("FAIL rnd_wb_en[%0d.%0d]: got %b want %b", r, i, e_wb, x_wb); end
            if (x_wb) begin
               n_cmp++; if ({e_addr, e_data} !== {REG_AW'(x_addr), DATA_W'(x_data)}) begin
                  n_bad++; $display("FAIL rnd_wb[%0d.%0d]: got r%0d=%0d want r%0d=%0d", r, i, e_addr, e_data, x_addr, x_data);
               end
            end
            n_cmp++; if ({n_pc, n_z, n_c, n_h, n_wb} !== {PC_W'(m_pc), m_z, m_c, m_halt, 1'b0}) begin
               n_bad++; $display("FAIL rnd_state[%0d.%0d]: got pc=%0d z=%b c=%b h=%b wb=%b want pc=%0d z=%b c=%b h=%b wb=0",
                                 r, i, n_pc, n_z, n_c, n_h, n_wb, m_pc, m_z, m_c, m_halt);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_flags();
      test_branch();
      test_wrap();
      test_stall();
      test_reset_mid_exec();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/risc_core_multicycle.md
Name: risc_core_multicycle

Overview:
- Parametrised successor to the fixed 4-bit single-instruction datapath.
- Adds a real program counter that increments, wraps and branches, a two-state fetch/execute sequencer, and a reset-clearable register file.
- Adds a non-overlapping rd field, carry/zero flags, load-immediate, conditional branch and halt.
- Sits between an external combinational program memory and the debug/observation logic.

Parameters:
- DATA_W, 4, register/ALU data width in bits (>=2).
- REG_AW, 2, register address width; register file holds 2**REG_AW registers.
- PC_W, 4, program counter width; program space 2**PC_W instructions.
- INSTR_W, 3+3*REG_AW, instruction width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  PC_W  program memory address; always equals pc.
- imem_data  input  INSTR_W  instruction at imem_addr; combinational, valid same cycle.
- stall  input  1  when high in FETCH, hold in FETCH; no IR load, no PC change.
- pc  output  PC_W  current program counter.
- halted  output  1  high once HALT has executed.
- wb_en  output  1  one-cycle pulse when a register is written.
- wb_addr  output  REG_AW  register written this cycle.
- wb_data  output  DATA_W  value written this cycle.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry/borrow flag.

Behaviour:
- Reset (async assert, sync release): pc=0, IR=0, all registers=0, flags=0, halted=0, wb_en=0, state=FETCH.
- Reset asserted mid-instruction aborts it; no write occurs.
- Instruction fields, MSB first: opcode[3], rs1[REG_AW], rs2[REG_AW], rd[REG_AW].
- States: FETCH, EXEC, HALT.
- FETCH -> EXEC when stall=0: IR <= imem_data.
- EXEC -> FETCH for all opcodes except HALT; EXEC -> HALT on HALT.
- HALT is terminal until reset.
- Throughput: 2 cycles per instruction. Register write and flag update occur on the EXEC clock edge; wb_en is high during EXEC only when a write happens.
- Operands A=reg[rs1], B=reg[rs2]; results truncated to DATA_W.
  - 000 ADD: rd<=A+B; C=carry out of bit DATA_W-1.
  - 001 SUB: rd<=A-B; C=1 when A<B (borrow).
  - 010 AND, 011 OR, 100 XOR: rd<=result; C<=0.
  - 101 LDI: rd <= zero-extended {rs1,rs2}, truncated to DATA_W; flags unchanged.
  - 110 BEQZ: if reg[rs1]==0, pc <= {rs2,rd} resized to PC_W, else pc+1. No write; flags unchanged.
  - 111 HALT: halted<=1; pc unchanged; no write.
- Z = (result==0) for ADD/SUB/AND/OR/XOR only.
- PC: pc<=pc+1 mod 2**PC_W at end of EXEC for non-branch, non-HALT instructions; pc=2**PC_W-1 wraps to 0.
- Writes to any register, including r0, are allowed; r0 is not hardwired.
- The rd==rs1 or rd==rs2 case reads old values (reads are combinational, the write is registered).
- stall is ignored in EXEC and HALT; an instruction in flight always completes.
- wb_addr and wb_data hold their last values when wb_en=0.

Test Plan:
- Reset then program {LDI r1,3; LDI r2,2; ADD r3=r1+r2; HALT} -> wb pulses (1,3),(2,2),(3,5); halted=1 at cycle 8; pc stays 3.
- r1=15, r2=1, ADD r0=r1+r2 -> r0=0, flag_z=1, flag_c=1; SUB r0=r2-r1 -> r0=2, flag_c=1, flag_z=0.
- r1=0, BEQZ r1 to target 0xA -> pc=10 next FETCH; with r1=1 -> pc=old+1; no wb_en pulse either way.
- Straight-line LDIs from pc=14 -> pc sequence 14,15,0 (wrap), no halt.
- stall held high for 5 cycles in FETCH -> pc, registers and IR frozen; release -> instruction executes normally 2 cycles later.
- rst_n asserted during EXEC of ADD -> no wb_en; all registers, pc and flags read 0 immediately (asynchronous).
